// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared state encoding, counter width and round-robin helper
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

  localparam int WR_COUNT_W = 16;
  localparam int MAX_NREQ   = 8;

  // First set bit searching upward from ptr+1 with wrap; returns ptr when req is empty.
  function automatic logic [2:0] next_winner(input logic [MAX_NREQ-1:0] req,
                                             input logic [2:0]          ptr,
                                             input int                  nreq);
    logic [2:0] win;
    int         idx;
    win = ptr;
    for (int k = MAX_NREQ; k >= 1; k--) begin
      if (k <= nreq) begin
        idx = (int'(ptr) + k) % nreq;
        if (req[3'(idx)]) win = 3'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_if.sv
// rtl/dff_write_arbiter_if.sv - requester-side bundle of the shared register arbiter
interface dff_write_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic [WR_COUNT_W-1:0] wr_count;

  modport master (output req, wdata, input ack, q, busy, grant_id, wr_count);
  modport slave  (input req, wdata, output ack, q, busy, grant_id, wr_count);

endinterface

// File: rtl/dff_reg_en.sv
// rtl/dff_reg_en.sv - WIDTH-bit load-enabled register with async active-low clear
module dff_reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - round-robin req/ack arbiter, sole writer of a shared register
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic                clk,
  input logic                rst_n,
  dff_write_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_WRITE = WRITE;
  localparam logic [1:0] S_ACK   = ACK;

  logic [1:0]            r_state;
  logic [IDW-1:0]        r_grant;
  logic [IDW-1:0]        r_ptr;
  logic [NREQ-1:0]       r_ack;
  logic [WR_COUNT_W-1:0] r_wr_count;

  logic [IDW-1:0]        w_winner;
  logic                  w_load;
  logic [WIDTH-1:0]      w_wdata_sel;

  assign w_winner    = IDW'(next_winner(MAX_NREQ'(bus.req), 3'(r_ptr), NREQ));
  assign w_load      = (r_state == S_WRITE);
  assign w_wdata_sel = bus.wdata[r_grant*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_ptr      <= IDW'(NREQ - 1);
      r_ack      <= '0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_grant <= w_winner;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
          r_ack   <= NREQ'(1) << r_grant;
          r_state <= S_ACK;
        end
        S_ACK: begin
          // A req dropped early (even during WRITE) still yields a one-cycle ack.
          if (!bus.req[r_grant]) begin
            r_ptr   <= r_grant;
            r_ack   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ack   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  dff_reg_en #(.WIDTH(WIDTH)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_load),
    .i_d   (w_wdata_sel),
    .o_q   (bus.q)
  );

  assign bus.ack      = r_ack;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_id = r_grant;
  assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb/tb_dff_write_arbiter.sv - directed and randomized bench for dff_write_arbiter
module tb_dff_write_arbiter;
  import dff_arb_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  int         m_ptr;
  int         m_cnt;
  logic [W-1:0] m_q;

  dff_write_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  dff_write_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic do_txn(input string tag, input logic [N-1:0] mask,
                        input logic [N*W-1:0] data, input int hold, input int exp_w);
    bus.req   = mask;
    bus.wdata = data;
    tick;
    chk({tag, ".grant"}, 32'(bus.grant_id), exp_w);
    chk({tag, ".busy"}, 32'(bus.busy), 1);
    chk({tag, ".ack_early"}, 32'(bus.ack), 0);
    tick;
    m_cnt = sat_inc(m_cnt);
    m_q   = data[exp_w*W +: W];
    chk({tag, ".ack"}, 32'(bus.ack), 32'(1) << exp_w);
    chk({tag, ".q"}, 32'(bus.q), 32'(m_q));
    chk({tag, ".count"}, 32'(bus.wr_count), m_cnt);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk({tag, ".ack_hold"}, 32'(bus.ack), 32'(1) << exp_w);
    end
    bus.req[exp_w] = 1'b0;
    tick;
    chk({tag, ".ack_drop"}, 32'(bus.ack), 0);
    chk({tag, ".idle"}, 32'(bus.busy), 0);
    chk({tag, ".q_keep"}, 32'(bus.q), 32'(m_q));
    m_ptr = exp_w;
  endtask

  initial begin
    int         order [6];
    logic [N-1:0] mask;
    order     = '{0, 1, 2, 3, 0, 1};
    bus.req   = '0;
    bus.wdata = '0;
    m_ptr     = N - 1;
    m_cnt     = 0;
    m_q       = '0;

    #3;
    chk("reset.q", 32'(bus.q), 0);
    chk("reset.ack", 32'(bus.ack), 0);
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.grant", 32'(bus.grant_id), 0);
    chk("reset.count", 32'(bus.wr_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_txn("fair", 4'hF, 32'($urandom), int'($urandom_range(0, 2)), order[i]);
    end

    do_txn("single", 4'b0010, 32'h0000_5A00, 3, 1);
    chk("single.total", 32'(bus.wr_count), 7);

    do_txn("to2", 4'b0100, 32'h0033_0000, 0, 2);
    do_txn("simul", 4'b0101, 32'h0044_0011, 0, 0);

    // Requester 3 withdraws while its write is already under way.
    bus.req   = 4'b1000;
    bus.wdata = 32'hC300_0000;
    tick;
    chk("viol.grant", 32'(bus.grant_id), 3);
    bus.req = 4'b0000;
    tick;
    m_cnt = sat_inc(m_cnt);
    chk("viol.ack", 32'(bus.ack), 32'h8);
    chk("viol.q", 32'(bus.q), 32'hC3);
    chk("viol.count", 32'(bus.wr_count), m_cnt);
    tick;
    chk("viol.ack_one", 32'(bus.ack), 0);
    chk("viol.idle", 32'(bus.busy), 0);
    tick;
    chk("viol.stay_idle", 32'(bus.busy), 0);
    m_ptr = 3;

    bus.req   = 4'b0001;
    bus.wdata = 32'h0000_00A5;
    tick;
    tick;
    chk("rst.pre_q", 32'(bus.q), 32'hA5);
    chk("rst.pre_ack", 32'(bus.ack), 32'h1);
    tick;
    rst_n = 1'b0;
    #1;
    chk("rst.q", 32'(bus.q), 0);
    chk("rst.ack", 32'(bus.ack), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.count", 32'(bus.wr_count), 0);
    m_ptr   = N - 1;
    m_cnt   = 0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn("rst.first", 4'b0100, 32'h003C_0000, 0, 2);

    for (int i = 0; i < 20; i++) begin
      mask = 4'($urandom_range(1, 15));
      do_txn("rand", mask, 32'($urandom), int'($urandom_range(0, 2)), model_pick(mask));
    end

    bus.req = '0;
    tick;
    force dut.r_wr_count = 16'hFFFE;
    #1;
    release dut.r_wr_count;
    m_cnt = 65534;
    for (int i = 0; i < 3; i++) begin
      mask = 4'($urandom_range(1, 15));
      do_txn("sat", mask, 32'($urandom), 0, model_pick(mask));
    end
    chk("sat.final", 32'(bus.wr_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
